// File: rtl/mux10.sv
// Registered 10-to-1 word selector; select codes 10-15 give a zero word and raise s_err.
// Latency 1 cycle, no backpressure: the output register captures every edge.
module mux10 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic [WIDTH-1:0] d8,
    input  logic [WIDTH-1:0] d9,
    input  logic [3:0]       s,
    output logic [WIDTH-1:0] y,
    output logic             s_err
);

    logic [WIDTH-1:0] sel_data;
    logic             err_next;

    // The default arm also catches X/Z on s, so no stale word can be held.
    always_comb begin
        sel_data = '0;
        err_next = 1'b0;
        case (s)
            4'd0:    sel_data = d0;
            4'd1:    sel_data = d1;
            4'd2:    sel_data = d2;
            4'd3:    sel_data = d3;
            4'd4:    sel_data = d4;
            4'd5:    sel_data = d5;
            4'd6:    sel_data = d6;
            4'd7:    sel_data = d7;
            4'd8:    sel_data = d8;
            4'd9:    sel_data = d9;
            default: begin
                sel_data = '0;
                err_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y     <= '0;
            s_err <= 1'b0;
        end else begin
            y     <= sel_data;
            s_err <= err_next;
        end
    end

endmodule

// File: tb/tb_mux10.sv
// Directed bench for mux10: reset, sweep, out-of-range selects, isolation, async reset, same-cycle change.
module tb_mux10;

    logic        clk;
    logic        rst;
    logic [15:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, d9;
    logic [3:0]  s;
    logic [15:0] y;
    logic        s_err;

    int checks = 0;
    int fails  = 0;

    mux10 #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .d5(d5), .d6(d6), .d7(d7), .d8(d8), .d9(d9),
        .s(s), .y(y), .s_err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic load_defaults();
        d0 = 16'h000A; d1 = 16'h000B; d2 = 16'h000C; d3 = 16'h000D; d4 = 16'h000E;
        d5 = 16'h000F; d6 = 16'h0001; d7 = 16'h0002; d8 = 16'h0003; d9 = 16'h0004;
    endtask

    logic [15:0] sweep_exp [10];

    initial begin
        sweep_exp = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
                      16'h000F, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

        // Reset held across several edges
        rst = 1'b1;
        s   = 4'd0;
        load_defaults();
        #1;
        check("rst_y_t0", {16'h0, y}, 32'h0);
        check("rst_err_t0", {31'h0, s_err}, 32'h0);
        edge_sample();
        check("rst_y_e1", {16'h0, y}, 32'h0);
        edge_sample();
        check("rst_y_e2", {16'h0, y}, 32'h0);
        check("rst_err_e2", {31'h0, s_err}, 32'h0);
        rst = 1'b0;
        edge_sample();
        check("first_capture", {16'h0, y}, 32'h000A);

        // Full sweep
        for (int i = 0; i < 10; i++) begin
            s = 4'(i);
            edge_sample();
            check($sformatf("sweep_y_%0d", i), {16'h0, y}, {16'h0, sweep_exp[i]});
            check($sformatf("sweep_err_%0d", i), {31'h0, s_err}, 32'h0);
        end

        // Out-of-range selects
        s = 4'd10;
        edge_sample();
        check("oor10_y", {16'h0, y}, 32'h0);
        check("oor10_err", {31'h0, s_err}, 32'h1);
        s = 4'd15;
        edge_sample();
        check("oor15_y", {16'h0, y}, 32'h0);
        check("oor15_err", {31'h0, s_err}, 32'h1);
        s = 4'd3;
        edge_sample();
        check("ret3_y", {16'h0, y}, 32'h000D);
        check("ret3_err", {31'h0, s_err}, 32'h0);

        // Unselected inputs churn while s=4
        s = 4'd4;
        for (int i = 0; i < 6; i++) begin
            d0 = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
            d3 = 16'($urandom); d5 = 16'($urandom); d6 = 16'($urandom);
            d7 = 16'($urandom); d8 = 16'($urandom); d9 = 16'($urandom);
            edge_sample();
            check($sformatf("iso_y_%0d", i), {16'h0, y}, 32'h000E);
        end
        load_defaults();

        // Mid-stream asynchronous reset at s=6
        s = 4'd6;
        edge_sample();
        check("pre_rst_y", {16'h0, y}, 32'h0001);
        #2 rst = 1'b1;
        #1;
        check("async_rst_y", {16'h0, y}, 32'h0);
        check("async_rst_err", {31'h0, s_err}, 32'h0);
        #2 rst = 1'b0;
        s = 4'd7;
        edge_sample();
        check("post_rst_y", {16'h0, y}, 32'h0002);

        // s and selected data change together
        s = 4'd8;
        edge_sample();
        check("s8_y", {16'h0, y}, 32'h0003);
        s  = 4'd9;
        d9 = 16'hFFFF;
        edge_sample();
        check("same_cycle_y", {16'h0, y}, 32'hFFFF);
        check("same_cycle_err", {31'h0, s_err}, 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux10.md
# mux10

Registered 10-to-1 word selector. On every clock edge it captures one of ten WIDTH-bit data inputs, chosen by a 4-bit select code, into the output register. It sits in datapaths that pick one of ten operand or status sources and need a glitch-free, clock-aligned result. Out-of-range select codes are flagged and produce a defined zero output.

## Interface

Parameters:
- WIDTH, default 16, bit width of each data input and of y.

Ports. One clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset; clears y and s_err immediately on assertion.
- d0 … d9  input  WIDTH each  data sources; index n is selected by s == n.
- s  input  4  select code; legal values 0–9.
- y  output  WIDTH  registered selected data.
- s_err  output  1  registered flag; 1 when the s sampled at the last edge was 10–15.

## Operation

- Select decode is combinational: sel_data = d[s] for s in 0..9.
- For s in 10..15: sel_data = 0 and err_next = 1. Otherwise err_next = 0.
- At each rising clk edge with rst low:
  - y <= sel_data
  - s_err <= err_next
- No enable. The output register updates every cycle.
- Data inputs are passed through bit-exactly. There is no arithmetic, no sign handling and no width change.
- Any X or Z on s must not propagate a held value. The decode is a full case with an explicit default covering codes 10–15.
- y depends only on the currently selected input. Changes on unselected inputs have no effect.

## Timing

- Reset:
  - While rst is high: y = 0 and s_err = 0, asynchronously and independent of clk.
  - Deassertion is sampled at the next rising edge. The first capture happens on the first edge with rst low.
- Latency is 1 cycle. s and d* are sampled at edge k, and y and s_err reflect them from edge k until edge k+1.
- Back-to-back select changes on consecutive cycles are tracked every cycle. There is no hold-off.
- Simultaneous change of s and the selected d on the same cycle: the new s and its new data are both captured at the next edge.
- Reset asserted mid-stream: outputs clear immediately. The sequence restarts from the first edge after release, with no stale value.
- Inputs must meet setup and hold to clk. There is no internal synchronisation.

## Test plan

- Reset check:
  - Stimulus: assert rst with s=0 and d0=0x000A, and toggle clk.
  - Required response: y=0x0000 and s_err=0 throughout.
  - After release, the first edge gives y=0x000A.
- Full sweep:
  - Stimulus: d0..d9 = 0x000A, 0x000B, 0x000C, 0x000D, 0x000E, 0x000F, 0x0001, 0x0002, 0x0003, 0x0004; step s from 0 to 9, one value per cycle.
  - Required response: y follows the same sequence one cycle later, with s_err=0 on every cycle.
- Out-of-range select:
  - Stimulus: s=10, then 15, with all d nonzero.
  - Required response: y=0x0000 and s_err=1 the cycle after each. Returning to s=3 gives y=0x000D and s_err=0.
- Isolation of unselected inputs:
  - Stimulus: hold s=4 with d4=0x000E, and randomise d0–d3 and d5–d9 each cycle.
  - Required response: y stays 0x000E.
- Mid-stream reset:
  - Stimulus: during the sweep at s=6, pulse rst asynchronously between edges.
  - Required response: y drops to 0x0000 without waiting for an edge. After release with s=7, the next edge gives y=0x0002.
- Same-cycle change:
  - Stimulus: in a single cycle, change s from 8 to 9 and d9 from 0x0004 to 0xFFFF.
  - Required response: next edge gives y=0xFFFF.
